// File: rtl/ibuffer_issue_arbiter_if.sv
// Issue-port bundle between the per-slot instruction buffers, the arbiter and dispatch.
// Request side is per-slot valid/ready; the out side is a single registered valid/ready beat.
interface ibuffer_issue_arbiter_if #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64
);
    localparam int SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS*DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]       req_last;
    logic [NUM_REQS-1:0]       req_ready;
    logic                      out_valid;
    logic [DATAW-1:0]          out_data;
    logic [SELW-1:0]           out_sel;
    logic                      out_last;
    logic                      out_ready;
    logic                      locked;
    logic                      group_err;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_sel, out_last, locked, group_err
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_sel, out_last, locked, group_err
    );
endinterface

// File: rtl/ibuffer_issue_arbiter.sv
// Round-robin issue arbiter that locks onto a requester for a whole micro-op group.
// Latency 1 (registered out stage, full rate); backpressure: all req_ready drop while out is held.
module ibuffer_issue_arbiter #(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = 64,
    parameter int MAX_GROUP = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    ibuffer_issue_arbiter_if.slave bus
);
    localparam int SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int CNTW = $clog2(MAX_GROUP + 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_GROUP - 1);
    localparam logic [SELW-1:0] TOP_SEL  = SELW'(NUM_REQS - 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t            state;
    logic [SELW-1:0]   rr_ptr;
    logic [SELW-1:0]   lock_id;
    logic [CNTW-1:0]   beat_cnt;
    logic [SELW-1:0]   grant;
    logic [SELW-1:0]   next_ptr;
    logic              grant_vld;
    logic              grant_last;
    logic [DATAW-1:0]  grant_data;
    logic              load;
    logic              xfer;
    logic              force_rel;
    int                idx;

    // Grant depends only on req_valid and state, never on the output stage.
    always_comb begin
        grant     = rr_ptr;
        grant_vld = 1'b0;
        idx       = 0;
        if (state == LOCKED) begin
            grant     = lock_id;
            grant_vld = bus.req_valid[lock_id];
        end else begin
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQS) idx = idx - NUM_REQS;
                if (bus.req_valid[idx]) begin
                    grant     = SELW'(idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign load       = !bus.out_valid || bus.out_ready;
    assign xfer       = grant_vld && load;
    assign grant_last = bus.req_last[grant];
    assign grant_data = bus.req_data[grant*DATAW +: DATAW];
    assign next_ptr   = (grant == TOP_SEL) ? '0 : grant + SELW'(1);
    // A group that reaches MAX_GROUP beats without a last flag is cut off here.
    assign force_rel  = (state == LOCKED) && !grant_last && (beat_cnt >= LAST_CNT);

    always_comb begin
        bus.req_ready = '0;
        if (xfer) bus.req_ready[grant] = 1'b1;
    end

    assign bus.locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARB;
            rr_ptr        <= '0;
            lock_id       <= '0;
            beat_cnt      <= '0;
            bus.group_err <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (load) begin
                bus.out_valid <= xfer;
                if (xfer) begin
                    bus.out_data <= grant_data;
                    bus.out_sel  <= grant;
                    bus.out_last <= grant_last || force_rel;
                end
            end
            if (xfer) begin
                if (state == ARB) begin
                    if (grant_last) begin
                        rr_ptr <= next_ptr;
                    end else begin
                        lock_id  <= grant;
                        beat_cnt <= CNTW'(1);
                        state    <= LOCKED;
                    end
                end else if (grant_last || force_rel) begin
                    state    <= ARB;
                    rr_ptr   <= next_ptr;
                    beat_cnt <= '0;
                    if (force_rel) bus.group_err <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + CNTW'(1);
                end
            end
        end
    end
endmodule

// File: doc/ibuffer_issue_arbiter.md
Name: ibuffer_issue_arbiter

Overview:
- Round-robin scheduler that shares one dispatch/issue port between NUM_REQS per-slot instruction-buffer outputs.
- Micro-op group aware: a group is a multi-beat expansion such as an MMUL sequence. Once its first beat is granted, the port is locked to that requester until the beat flagged last is transferred, so groups never interleave.
- Sits between the per-issue-slot instruction buffers and the scoreboard/dispatch stage.
- Registers its output: one-entry output stage, full throughput.

Parameters:
- NUM_REQS, 4, number of requesting instruction-buffer slots (>=2).
- DATAW, 64, payload width per beat.
- MAX_GROUP, 4, maximum beats per micro-op group before forced release (>=2).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQS  per-requester beat valid.
- req_data  input  NUM_REQS*DATAW  per-requester payload; requester i occupies bits [i*DATAW +: DATAW].
- req_last  input  NUM_REQS  beat ends its group (1 for ordinary single-beat instructions).
- req_ready  output  NUM_REQS  per-requester accept; one-hot or zero.
- out_valid  output  1  registered beat valid.
- out_data  output  DATAW  registered payload.
- out_sel  output  LOG2UP(NUM_REQS)  index of the requester that produced out_data.
- out_last  output  1  registered copy of req_last.
- out_ready  input  1  downstream accept.
- locked  output  1  arbiter is held inside a group.
- group_err  output  1  sticky; a group exceeded MAX_GROUP beats.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, out_sel=0, out_last=0, locked=0, group_err=0, rr_ptr=0, beat_cnt=0, state=ARB.
  - Reset asserted mid-group drops the lock and any beat held in the output register. The beat is lost.
- Load condition: load = !out_valid || out_ready.
  - A transfer occurs on requester g when req_valid[g] && load && grant==g.
  - Transferred beat appears on out_* the next cycle (latency 1).
  - Back-to-back transfers occur every cycle while out_ready=1.
- Ready rule:
  - req_ready[i] = load && (grant==i) && req_valid[i].
  - grant never depends on req_ready or out_valid of the same cycle, only on req_valid and state.
- State ARB:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQS.
  - If no request is valid, no grant and rr_ptr is unchanged.
  - On a transfer with req_last[g]=1: rr_ptr <= (g+1) mod NUM_REQS; stay in ARB.
  - On a transfer with req_last[g]=0: lock_id <= g, beat_cnt <= 1, state <= LOCKED.
- State LOCKED (locked=1):
  - grant = lock_id only. All other req_ready=0 even if lock_id is idle; bubbles are allowed and the lock is never broken by other requesters.
  - On a transfer with req_last=1: state <= ARB, rr_ptr <= (lock_id+1) mod NUM_REQS, beat_cnt <= 0.
  - On a transfer with req_last=0:
    - beat_cnt+1 < MAX_GROUP: beat_cnt <= beat_cnt+1.
    - Otherwise (MAX_GROUP-th beat without last): group_err <= 1, forced release exactly as if last, out_last of that beat = 1.
- Arithmetic:
  - beat_cnt is LOG2UP(MAX_GROUP+1) bits and never wraps.
  - rr_ptr wraps NUM_REQS-1 -> 0.
- Stall: while out_valid && !out_ready, the output registers hold their values and all req_ready=0. State and rr_ptr do not change.
- group_err clears only on reset.
- No combinational path from out_ready to out_valid/out_data.

Test Plan:
- Reset, then req_valid=4'b1111, all req_last=1, out_ready=1 -> out_sel sequence 0,1,2,3,0, one per cycle, starting the cycle after the first accept.
- req_valid[1] group of 3 beats (last on beat 3) while req_valid[2] is held high -> out_sel 1,1,1 then 2; locked=1 for exactly the 2 cycles between beat 1 and beat 3 accept.
- Locked on requester 0, req_valid[0] drops for 2 cycles while req_valid[3]=1 -> req_ready[3]=0 throughout, out_valid=0 bubbles, the group resumes on 0, then 3 is granted.
- MAX_GROUP=4, requester 2 sends 5 beats all with last=0 -> beat 4 emitted with out_last=1, group_err=1 thereafter, locked=0, and beat 5 re-arbitrated normally.
- out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, req_ready=4'b0000, rr_ptr unchanged; on release, the next grant resumes the round-robin order.
- reset pulsed low asynchronously mid-group (between clock edges) -> out_valid=0 and locked=0 immediately; after release, arbitration restarts at requester 0.
